mpu_phase_sequencer: RTL



---
 rtl/mpu_phase_sequencer.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/mpu_phase_sequencer.sv
// MPU instruction-cycle sequencer: fetches opcode/operands, strobes EXEC/WB, owns the PC, handles HALT.
// Latency 4 cycles (no operands) to 7 cycles (three); a fetch phase stalls until mem_valid_i.
module mpu_phase_sequencer #(
    parameter int PC_WIDTH    = 12,
    parameter int INSTR_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   halt_i,
    output logic                   mem_req_o,
    input  logic                   mem_valid_i,
    input  logic [INSTR_WIDTH-1:0] mem_data_i,
    output logic [PC_WIDTH-1:0]    pc_o,
    output logic [2:0]             phase_o,
    output logic [INSTR_WIDTH-1:0] instr_o,
    output logic [INSTR_WIDTH-1:0] operand_o,
    output logic                   operand_we_o,
    output logic [1:0]             operand_idx_o,
    output logic                   exec_en_o,
    output logic                   wb_en_o,
    input  logic                   branch_take_i,
    input  logic [PC_WIDTH-1:0]    branch_target_i,
    output logic                   halted_o
);

    typedef enum logic [2:0] {
        PH_IF     = 3'b000,
        PH_DEC    = 3'b001,
        PH_OP3    = 3'b010,
        PH_OP2    = 3'b011,
        PH_OP1    = 3'b100,
        PH_EXEC   = 3'b101,
        PH_WB     = 3'b110,
        PH_HALTED = 3'b111
    } phase_t;

    phase_t                 phase_q, phase_d;
    phase_t                 saved_q, saved_d;
    phase_t                 succ;
    logic [PC_WIDTH-1:0]    pc_q, pc_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic [INSTR_WIDTH-1:0] operand_q, operand_d;
    logic [1:0]             idx_q, idx_d;
    logic                   we_q, we_d;
    logic                   req_q, exec_q, wb_q, halted_q;
    logic                   fetch_phase;

    always_comb begin
        phase_d     = phase_q;
        saved_d     = saved_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        operand_d   = operand_q;
        idx_d       = idx_q;
        we_d        = 1'b0;
        succ        = PH_IF;
        fetch_phase = 1'b0;
        case (phase_q)
            PH_IF: begin
                fetch_phase = 1'b1;
                succ        = PH_DEC;
                if (mem_valid_i) begin
                    instr_d = mem_data_i;
                    pc_d    = pc_q + PC_WIDTH'(1);
                end
            end
            PH_DEC: begin
                case (instr_q[INSTR_WIDTH-1 -: 2])
                    2'b11:   succ = PH_OP3;
                    2'b10:   succ = PH_OP2;
                    2'b01:   succ = PH_OP1;
                    default: succ = PH_EXEC;
                endcase
            end
            PH_OP3, PH_OP2, PH_OP1: begin
                fetch_phase = 1'b1;
                succ = (phase_q == PH_OP3) ? PH_OP2 : (phase_q == PH_OP2) ? PH_OP1 : PH_EXEC;
                if (mem_valid_i) begin
                    operand_d = mem_data_i;
                    we_d      = 1'b1;
                    idx_d     = (phase_q == PH_OP3) ? 2'd3 : (phase_q == PH_OP2) ? 2'd2 : 2'd1;
                    pc_d      = pc_q + PC_WIDTH'(1);
                end
            end
            PH_EXEC: succ = PH_WB;
            PH_WB: begin
                succ = PH_IF;
                if (branch_take_i) pc_d = branch_target_i;
            end
            default: succ = PH_IF;
        endcase

        if (phase_q == PH_HALTED) begin
            // A corrupt saved phase must never re-enter HALTED on release.
            if (!halt_i) phase_d = (saved_q == PH_HALTED) ? PH_IF : saved_q;
        end else if (fetch_phase && !mem_valid_i) begin
            if (halt_i) begin
                saved_d = phase_q;
                phase_d = PH_HALTED;
            end
        end else if (halt_i) begin
            saved_d = succ;
            phase_d = PH_HALTED;
        end else begin
            phase_d = succ;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q   <= PH_IF;
            saved_q   <= PH_IF;
            pc_q      <= '0;
            instr_q   <= '0;
            operand_q <= '0;
            idx_q     <= 2'd0;
            we_q      <= 1'b0;
            req_q     <= 1'b1;
            exec_q    <= 1'b0;
            wb_q      <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            phase_q   <= phase_d;
            saved_q   <= saved_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            operand_q <= operand_d;
            idx_q     <= idx_d;
            we_q      <= we_d;
            req_q     <= (phase_d == PH_IF) || (phase_d == PH_OP3) ||
                         (phase_d == PH_OP2) || (phase_d == PH_OP1);
            exec_q    <= (phase_d == PH_EXEC);
            wb_q      <= (phase_d == PH_WB);
            halted_q  <= (phase_d == PH_HALTED);
        end
    end

    assign mem_req_o     = req_q;
    assign pc_o          = pc_q;
    assign phase_o       = phase_q;
    assign instr_o       = instr_q;
    assign operand_o     = operand_q;
    assign operand_we_o  = we_q;
    assign operand_idx_o = idx_q;
    assign exec_en_o     = exec_q;
    assign wb_en_o       = wb_q;
    assign halted_o      = halted_q;

endmodule
